// File: rtl/mul_div_unit_if.sv
// HI/LO multiply-divide unit bus: operation request, architectural HI/LO and busy/stall status.
// Handshake: start is sampled at a rising edge only while the unit is idle (busy == 0); no ready signal is returned, the issuer stalls on busy != 0.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [2:0]  busy;
  logic [1:0]  state;

  modport master (output start, op, a, b, input hi, lo, busy, state);
  modport slave  (input start, op, a, b, output hi, lo, busy, state);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers and a busy stall vector.
// Optional multiply-accumulate (op 6/7) is enabled by defining MDU_MADD_EN.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);

  state_t      state = IDLE;
  state_t      state_n;
  logic [3:0]  cnt   = '0;
  logic [3:0]  cnt_n;
  logic [31:0] hi_q  = '0;
  logic [31:0] lo_q  = '0;
  logic [31:0] hi_n, lo_n;
  logic [31:0] a_q   = '0;
  logic [31:0] b_q   = '0;
  logic [2:0]  op_q  = '0;
  logic        load;

  logic [63:0] prod_s, prod_u, result;
  logic        wr_en;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  // Low 64 bits of a sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
  assign div_signed = (op_q == 3'd2);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? -a_q : a_q;
  assign b_mag      = b_neg ? -b_q : b_q;
  assign q_mag      = (b_q == '0) ? '0 : a_mag / b_mag;
  assign r_mag      = (b_q == '0) ? '0 : a_mag % b_mag;
  assign quo        = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

  always_comb begin
    result = {hi_q, lo_q};
    wr_en  = 1'b1;
    case (op_q)
      3'd0:       result = prod_s;
      3'd1:       result = prod_u;
      3'd2, 3'd3: begin
        result = {rem, quo};
        wr_en  = (b_q != '0);
      end
`ifdef MDU_MADD_EN
      3'd6:       result = {hi_q, lo_q} + prod_s;
      3'd7:       result = {hi_q, lo_q} + prod_u;
`endif
      default:    result = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi_q;
    lo_n    = lo_q;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              state_n = MUL;
              cnt_n   = MC;
              load    = 1'b1;
            end
            3'd2, 3'd3: begin
              state_n = DIV;
              cnt_n   = DC;
              load    = 1'b1;
            end
            3'd4: hi_n = bus.a;
            3'd5: lo_n = bus.a;
`ifdef MDU_MADD_EN
            3'd6, 3'd7: begin
              state_n = MUL;
              cnt_n   = MC;
              load    = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_n = IDLE;
          if (wr_en) {hi_n, lo_n} = result;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (load) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.op;
      end
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = {(state != IDLE) && (cnt == 4'd1), state == DIV, state == MUL};
  assign bus.state = state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes reference results, a negedge monitor checks busy timing and HI/LO.
module tb_mul_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mul_div_unit_if bus();

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] pre_q[$];
  int          len_q[$];
  logic [1:0]  kind_q[$];
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;
  bit          aborted = 0;
  int          mon_cnt = 0;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the operands.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] acc);
    int xi = x;
    int yi = y;
    longint sx = xi;
    longint sy = yi;
    longint unsigned ux = x;
    longint unsigned uy = y;
    longint q, r;
    longint unsigned uq, ur;
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 0) return acc;
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 0) return acc;
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      3'd6: return acc + sx * sy;
      3'd7: return acc + ux * uy;
      default: return acc;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy != 3'b000 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", 64'(bus.busy), 64'd0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit wait_done);
    bit mdu = 0;
    logic [63:0] post;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    if (o <= 3'd3 || (o >= 3'd6 && MADD_EN)) begin
      post = ref_op(o, x, y, {mhi, mlo});
      pre_q.push_back({mhi, mlo});
      exp_q.push_back(post);
      len_q.push_back((o inside {3'd2, 3'd3}) ? DC : MC);
      kind_q.push_back((o inside {3'd2, 3'd3}) ? 2'b10 : 2'b01);
      {mhi, mlo} = post;
      mdu = 1;
    end else if (o == 3'd4) begin
      mhi = x;
    end else if (o == 3'd5) begin
      mlo = x;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    if (!mdu) begin
      chk("no_busy", 64'(bus.busy), 64'd0);
      chk("hilo_immediate", {bus.hi, bus.lo}, {mhi, mlo});
    end else if (wait_done) begin
      wait_idle();
    end
  endtask

  // Monitor: per busy cycle check busy encoding and HI/LO hold; on busy falling, compare result.
  always @(negedge clk) begin
    if (bus.busy != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("busy_unexpected", 64'(bus.busy), 64'd0);
      end else begin
        mon_cnt++;
        chk("busy_kind", 64'(bus.busy[1:0]), 64'(kind_q[0]));
        chk("busy_final", 64'(bus.busy[2]), 64'(mon_cnt == len_q[0]));
        chk("hilo_hold", {bus.hi, bus.lo}, pre_q[0]);
      end
    end else if (mon_cnt != 0) begin
      if (aborted) begin
        aborted = 0;
      end else begin
        chk("busy_length", 64'(mon_cnt), 64'(len_q[0]));
        chk("result_hilo", {bus.hi, bus.lo}, exp_q[0]);
      end
      void'(exp_q.pop_front());
      void'(pre_q.pop_front());
      void'(len_q.pop_front());
      void'(kind_q.pop_front());
      mon_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    chk("time0_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("time0_busy", 64'(bus.busy), 64'd0);

    // Start asserted during reset must be ignored.
    bus.start = 1'b1;
    bus.op    = 3'd4;
    bus.a     = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);

    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1);
    chk("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    issue(3'd3, 32'd100, 32'd7, 1);
    chk("divu_const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1);
    chk("div_neg_const", {bus.hi, bus.lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    issue(3'd5, 32'h1234, 32'd0, 1);
    issue(3'd2, 32'd77, 32'd0, 1);
    chk("div0_lo_const", 64'(bus.lo), 64'h1234);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    chk("div_ovf_const", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

    // Re-pulse div and mthi while a multu is running: both must be ignored.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd9; bus.b = 32'd4;
    @(posedge clk); #1;
    bus.op = 3'd4; bus.a = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_idle();
    chk("multu_const", {bus.hi, bus.lo}, {32'hFFFF_FFFE, 32'd1});

    // Reset during busy cycle 4 of a divide aborts it.
    issue(3'd3, 32'd1000, 32'd3, 0);
    repeat (3) begin @(posedge clk); #1; end
    aborted = 1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mhi = '0;
    mlo = '0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    issue(3'd0, 32'd6, 32'd7, 1);

    issue(3'd4, 32'd0, 32'd0, 1);
    issue(3'd5, 32'd5, 32'd0, 1);
    issue(3'd7, 32'd2, 32'd3, 1);
    chk("maddu_lo_const", 64'(bus.lo), MADD_EN ? 64'd11 : 64'd5);

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 5) == 0) y = 32'd0;
      if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      issue(o, x, y, 1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles per multiply (range 2..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles per divide (range 2..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to launch the operation in op.
REQ-006 SHALL have port op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
REQ-007 SHALL have ports a, b  input  32 each  operands (a = rs/dividend, b = rt/divisor).
REQ-008 SHALL have ports hi, lo  output  32 each  architectural HI/LO registers.
REQ-009 SHALL have port busy  output  3  [0] multiply running, [1] divide running, [2] final busy cycle; the PC and pipeline registers stall while busy != 0.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV; a 4-bit down-counter tracks the remaining busy cycles.
REQ-011 SHALL accept start only in IDLE; start while in MUL or DIV SHALL be ignored, with no effect on the operation in flight.
REQ-012 SHALL, on an accepted start with op 0/1/6/7 at edge T, enter MUL and hold busy[0]=1 for exactly MULT_CYCLES cycles after T.
REQ-013 SHALL, on an accepted start with op 2/3 at edge T, enter DIV and hold busy[1]=1 for exactly DIV_CYCLES cycles after T.
REQ-014 SHALL assert busy[2] only during the last busy cycle of each operation.
REQ-015 SHALL latch a, b and op at the accepted start; later changes to a, b and op SHALL NOT affect the result.
REQ-016 SHALL update hi/lo at the edge that ends the last busy cycle and return to IDLE at that edge, so the new values are visible in the first non-busy cycle.
REQ-017 SHALL hold hi/lo at their old values throughout the busy period.
REQ-018 SHALL compute mult as the signed 64-bit product {hi,lo}=a*b and multu as the unsigned product.
REQ-019 SHALL compute div as signed with lo=quotient truncated toward zero and hi=remainder carrying the sign of the dividend.
REQ-020 SHALL compute divu as unsigned with lo=quotient and hi=remainder.
REQ-021 SHALL, for div with 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0.
REQ-022 SHALL, when the divisor is 0, still run the full DIV_CYCLES busy period and leave hi/lo unchanged.
REQ-023 SHALL, for mthi/mtlo with start in IDLE, write a into hi/lo at that edge, assert no busy and stay in IDLE.
REQ-024 SHALL ignore mthi/mtlo issued while busy.
REQ-025 SHALL allow a new start in the first IDLE cycle after completion; back-to-back operations SHALL have no idle gap.

Reset
REQ-026 SHALL, when reset=1 at an edge, force hi=0, lo=0, busy=0, state=IDLE and counter=0, regardless of start.
REQ-027 SHALL, on reset mid-operation, abort the operation and discard its result.
REQ-028 SHALL have hi, lo and busy equal to 0 at time zero, before the first reset.

Configuration
REQ-029 SHALL be controlled by macro MDU_MADD_EN.
REQ-030 SHALL, with MDU_MADD_EN defined, add the signed (op 6) or unsigned (op 7) 64-bit product to {hi,lo} held at the accepted start, wrapping modulo 2^64, with multiply latency.
REQ-031 SHALL, without MDU_MADD_EN, treat op 6/7 as no-ops: not accepted, no busy, hi/lo unchanged.

Verification
REQ-032 SHALL pass: reset, then mult a=0xFFFFFFFE, b=3 -> busy[0]=1 for 5 cycles, busy[2]=1 in cycle 5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 SHALL pass: divu a=100, b=7 -> busy[1]=1 for 10 cycles, then lo=14, hi=2; div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL pass: mtlo a=0x1234 then div b=0 -> 10 busy cycles, then lo=0x1234 unchanged; div 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-035 SHALL pass: start multu a=b=0xFFFFFFFF, re-pulse start with a div at busy cycle 3 -> ignored, total busy 5 cycles, then hi=0xFFFFFFFE, lo=1.
REQ-036 SHALL pass: div started, reset at busy cycle 4 -> next cycle busy=0, hi=lo=0; start at the next edge accepted normally.
REQ-037 SHALL pass, with MDU_MADD_EN: mthi 0, mtlo 5, maddu a=2, b=3 -> lo=11, hi=0; without the macro: same op 7 -> busy stays 0 and lo=5.
